// File: rtl/sipo_rx.sv
// Framed LSB-first serial-to-parallel receiver with a one-word valid/ready output slot.
// Latency: word registered on the edge taking its last bit; a full slot drops the word and sets sticky overrun.
module sipo_rx #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         si,
   input  logic         si_en,
   input  logic         sof,
   output logic [W-1:0] po,
   output logic         po_valid,
   input  logic         po_ready,
   output logic         busy,
   output logic         overrun,
   input  logic         ovr_clr
);

   localparam int CW = $clog2(W) + 1;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t         state;
   logic [W-1:0]   sr;
   logic [CW-1:0]  cnt;
   logic [W-1:0]   nxt_word;

   assign nxt_word = {si, sr[W-1:1]};
   assign busy     = (state == SHIFT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         sr       <= '0;
         cnt      <= '0;
         po       <= '0;
         po_valid <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         // Clear first so a drop on the same edge overrides it.
         if (ovr_clr)
            overrun <= 1'b0;
         if (po_valid && po_ready)
            po_valid <= 1'b0;

         if (si_en) begin
            case (state)
               IDLE: begin
                  if (sof) begin
                     sr    <= nxt_word;
                     cnt   <= CW'(1);
                     state <= SHIFT;
                  end
               end
               SHIFT: begin
                  if (sof) begin
                     sr  <= nxt_word;
                     cnt <= CW'(1);
                  end else if (cnt == CW'(W - 1)) begin
                     sr    <= nxt_word;
                     cnt   <= '0;
                     state <= IDLE;
                     if (!po_valid || po_ready) begin
                        po       <= nxt_word;
                        po_valid <= 1'b1;
                     end else begin
                        overrun  <= 1'b1;
                     end
                  end else begin
                     sr  <= nxt_word;
                     cnt <= cnt + CW'(1);
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sipo_rx.sv
// Directed bench for sipo_rx: stimulus pushes expected words, a negedge monitor pops on each transfer.
module tb_sipo_rx;

   logic       clk = 1'b0;
   logic       rst;
   logic       si;
   logic       si_en;
   logic       sof;
   logic [3:0] po;
   logic       po_valid;
   logic       po_ready;
   logic       busy;
   logic       overrun;
   logic       ovr_clr;

   int vectors = 0;
   int errors  = 0;
   logic [3:0] exp_q[$];

   sipo_rx #(.W(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .si       (si),
      .si_en    (si_en),
      .sof      (sof),
      .po       (po),
      .po_valid (po_valid),
      .po_ready (po_ready),
      .busy     (busy),
      .overrun  (overrun),
      .ovr_clr  (ovr_clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transfers happen on the next rising edge whenever valid and ready are both high here.
   always @(negedge clk) begin
      if (!rst && po_valid && po_ready) begin
         if (exp_q.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL unexpected_word: got %0h expected none at %0t", po, $time);
         end else begin
            check("word", 32'(po), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic send_bit(input logic b, input logic s);
      si    = b;
      sof   = s;
      si_en = 1'b1;
      @(posedge clk); #1;
      si_en = 1'b0;
      sof   = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      rst      = 1'b1;
      si       = 1'b0;
      si_en    = 1'b0;
      sof      = 1'b0;
      po_ready = 1'b1;
      ovr_clr  = 1'b0;
      #12;
      check("rst_po", 32'(po), 32'h0);
      check("rst_po_valid", 32'(po_valid), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_overrun", 32'(overrun), 32'h0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Basic frame 0,1,0,1 -> 4'b1010
      exp_q.push_back(4'b1010);
      send_bit(1'b0, 1'b1);
      check("basic_busy1", 32'(busy), 32'h1);
      send_bit(1'b1, 1'b0);
      check("basic_busy2", 32'(busy), 32'h1);
      send_bit(1'b0, 1'b0);
      check("basic_busy3", 32'(busy), 32'h1);
      send_bit(1'b1, 1'b0);
      check("basic_busy_done", 32'(busy), 32'h0);
      check("basic_valid", 32'(po_valid), 32'h1);
      check("basic_po", 32'(po), 32'ha);
      idle(1);
      check("basic_valid_drop", 32'(po_valid), 32'h0);

      // Gapped strobe, preceded by a non-sof bit in IDLE
      send_bit(1'b1, 1'b0);
      check("idle_nosof_busy", 32'(busy), 32'h0);
      exp_q.push_back(4'b1010);
      send_bit(1'b0, 1'b1);
      idle(2);
      check("gap_busy", 32'(busy), 32'h1);
      send_bit(1'b1, 1'b0);
      idle(2);
      send_bit(1'b0, 1'b0);
      idle(2);
      check("gap_valid_pre", 32'(po_valid), 32'h0);
      send_bit(1'b1, 1'b0);
      check("gap_po", 32'(po), 32'ha);
      check("gap_valid", 32'(po_valid), 32'h1);
      idle(1);

      // Backpressure: second word dropped
      po_ready = 1'b0;
      exp_q.push_back(4'b1010);
      send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
      check("bp_po", 32'(po), 32'ha);
      check("bp_valid", 32'(po_valid), 32'h1);
      check("bp_overrun", 32'(overrun), 32'h1);
      idle(2);
      check("bp_po_stable", 32'(po), 32'ha);
      check("bp_valid_stable", 32'(po_valid), 32'h1);
      po_ready = 1'b1;
      idle(1);
      check("bp_valid_drop", 32'(po_valid), 32'h0);
      check("bp_overrun_sticky", 32'(overrun), 32'h1);
      ovr_clr = 1'b1;
      idle(1);
      ovr_clr = 1'b0;
      check("ovr_clr", 32'(overrun), 32'h0);

      // Completion and accept on the same edge
      po_ready = 1'b0;
      exp_q.push_back(4'b1010);
      send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
      exp_q.push_back(4'b0110);
      send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
      po_ready = 1'b1;
      send_bit(1'b0, 1'b0);
      check("sim_po", 32'(po), 32'h6);
      check("sim_valid", 32'(po_valid), 32'h1);
      check("sim_overrun", 32'(overrun), 32'h0);
      idle(1);
      check("sim_valid_drop", 32'(po_valid), 32'h0);

      // Resync after two bits: only 1,1,0,0 -> 4'b0011 emerges
      send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b0);
      exp_q.push_back(4'b0011);
      send_bit(1'b1, 1'b1);
      check("resync_busy", 32'(busy), 32'h1);
      send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
      check("resync_no_early", 32'(po_valid), 32'h0);
      send_bit(1'b0, 1'b0);
      check("resync_po", 32'(po), 32'h3);
      check("resync_valid", 32'(po_valid), 32'h1);
      check("resync_overrun", 32'(overrun), 32'h0);

      // Asynchronous reset mid-frame, between edges
      send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b0);
      #2 rst = 1'b1;
      #1;
      check("arst_po", 32'(po), 32'h0);
      check("arst_valid", 32'(po_valid), 32'h0);
      check("arst_busy", 32'(busy), 32'h0);
      check("arst_overrun", 32'(overrun), 32'h0);
      #3 rst = 1'b0;
      @(posedge clk); #1;
      send_bit(1'b1, 1'b0);
      check("post_rst_nosof", 32'(busy), 32'h0);
      exp_q.push_back(4'b1001);
      send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
      check("post_rst_po", 32'(po), 32'h9);
      check("post_rst_valid", 32'(po_valid), 32'h1);
      idle(3);

      check("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
